// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width, register index width and ALU opcodes.
package cpu_pkg;

    localparam int DEFAULT_LEN = 32;
    localparam int REG_IDX_W   = 5;

    typedef enum logic [3:0] {
        ADD  = 4'b0000,
        SUB  = 4'b0001,
        AND  = 4'b0010,
        OR   = 4'b0011,
        XOR  = 4'b0100,
        SLT  = 4'b0101,
        SLTU = 4'b0110,
        SLL  = 4'b0111,
        SRL  = 4'b1000,
        BGE  = 4'b1001,
        BGEU = 4'b1010,
        SRA  = 4'b1011,
        SUB2 = 4'b1100,
        LUI  = 4'b1111
    } alu_ctrl_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Picks the freshest value of one source register from the EX/MEM and MEM/WB result buses.
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int LEN = DEFAULT_LEN
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [LEN-1:0]       rs_data,
    input  logic                 fwd_mem_valid,
    input  logic [REG_IDX_W-1:0] fwd_mem_rd,
    input  logic [LEN-1:0]       fwd_mem_data,
    input  logic                 fwd_wb_valid,
    input  logic [REG_IDX_W-1:0] fwd_wb_rd,
    input  logic [LEN-1:0]       fwd_wb_data,
    output logic [LEN-1:0]       operand
);

    // x0 is hardwired, so a bus claiming to write it must never override the read.
    // EX/MEM is younger than MEM/WB and therefore wins when both match.
    always_comb begin
        operand = rs_data;
        if (rs != '0) begin
            if (fwd_mem_valid && (fwd_mem_rd == rs)) begin
                operand = fwd_mem_data;
            end else if (fwd_wb_valid && (fwd_wb_rd == rs)) begin
                operand = fwd_wb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding; a stalled instruction keeps
// refreshing its register operands from the result buses until execute takes it.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int LEN = DEFAULT_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [LEN-1:0]       in_rs1_data,
    input  logic [LEN-1:0]       in_rs2_data,
    input  logic [LEN-1:0]       in_imm,
    input  logic [LEN-1:0]       in_pc,
    input  logic                 in_op1_pc,
    input  logic                 in_alu_src,
    input  logic [3:0]           in_alu_ctrl,
    input  logic                 in_reg_write,
    input  logic                 fwd_mem_valid,
    input  logic [REG_IDX_W-1:0] fwd_mem_rd,
    input  logic [LEN-1:0]       fwd_mem_data,
    input  logic                 fwd_wb_valid,
    input  logic [REG_IDX_W-1:0] fwd_wb_rd,
    input  logic [LEN-1:0]       fwd_wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LEN-1:0]       aluop1,
    output logic [LEN-1:0]       aluop2,
    output logic [3:0]           alu_ctrl,
    output logic [LEN-1:0]       out_store_data,
    output logic [LEN-1:0]       out_pc,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_reg_write
);

    logic                 capture;
    logic [REG_IDX_W-1:0] held_rs1;
    logic [REG_IDX_W-1:0] held_rs2;
    logic [LEN-1:0]       held_rs1_val;
    logic [LEN-1:0]       held_rs2_val;
    logic                 held_op1_pc;
    logic                 held_alu_src;
    logic [REG_IDX_W-1:0] sel_rs1;
    logic [REG_IDX_W-1:0] sel_rs2;
    logic [LEN-1:0]       sel_rs1_data;
    logic [LEN-1:0]       sel_rs2_data;
    logic [LEN-1:0]       fwd_rs1;
    logic [LEN-1:0]       fwd_rs2;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // The same muxes serve a new instruction and the refresh of a held one.
    assign sel_rs1      = capture ? in_rs1      : held_rs1;
    assign sel_rs2      = capture ? in_rs2      : held_rs2;
    assign sel_rs1_data = capture ? in_rs1_data : held_rs1_val;
    assign sel_rs2_data = capture ? in_rs2_data : held_rs2_val;

    operand_fwd_mux #(.LEN(LEN)) u_fwd_rs1 (
        .rs            (sel_rs1),
        .rs_data       (sel_rs1_data),
        .fwd_mem_valid (fwd_mem_valid),
        .fwd_mem_rd    (fwd_mem_rd),
        .fwd_mem_data  (fwd_mem_data),
        .fwd_wb_valid  (fwd_wb_valid),
        .fwd_wb_rd     (fwd_wb_rd),
        .fwd_wb_data   (fwd_wb_data),
        .operand       (fwd_rs1)
    );

    operand_fwd_mux #(.LEN(LEN)) u_fwd_rs2 (
        .rs            (sel_rs2),
        .rs_data       (sel_rs2_data),
        .fwd_mem_valid (fwd_mem_valid),
        .fwd_mem_rd    (fwd_mem_rd),
        .fwd_mem_data  (fwd_mem_data),
        .fwd_wb_valid  (fwd_wb_valid),
        .fwd_wb_rd     (fwd_wb_rd),
        .fwd_wb_data   (fwd_wb_data),
        .operand       (fwd_rs2)
    );

    // Reset beats flush, flush beats capture; a held instruction's register
    // values are rewritten each stall cycle so later results are not missed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            aluop1         <= '0;
            aluop2         <= '0;
            out_store_data <= '0;
            out_pc         <= '0;
            alu_ctrl       <= 4'b0000;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            held_rs1       <= '0;
            held_rs2       <= '0;
            held_rs1_val   <= '0;
            held_rs2_val   <= '0;
            held_op1_pc    <= 1'b0;
            held_alu_src   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid      <= 1'b1;
            aluop1         <= in_op1_pc  ? in_pc  : fwd_rs1;
            aluop2         <= in_alu_src ? in_imm : fwd_rs2;
            out_store_data <= fwd_rs2;
            out_pc         <= in_pc;
            alu_ctrl       <= in_alu_ctrl;
            out_rd         <= in_rd;
            out_reg_write  <= in_reg_write;
            held_rs1       <= in_rs1;
            held_rs2       <= in_rs2;
            held_rs1_val   <= fwd_rs1;
            held_rs2_val   <= fwd_rs2;
            held_op1_pc    <= in_op1_pc;
            held_alu_src   <= in_alu_src;
        end else if (out_valid && !out_ready) begin
            held_rs1_val   <= fwd_rs1;
            held_rs2_val   <= fwd_rs2;
            out_store_data <= fwd_rs2;
            if (!held_op1_pc) begin
                aluop1 <= fwd_rs1;
            end
            if (!held_alu_src) begin
                aluop2 <= fwd_rs2;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
